// File: rtl/rc4_seq_pkg.sv
// Shared types for the RC4 key-search sequencer.
//   state_e  : sequencer state, also driven out as the 3-bit phase code
//   client_e : S-memory client index (INIT=0, SHUFFLE=1, DECRYPT=2, none=3)
//   s_req_t  : one S-memory request {addr, data, wren}
package rc4_seq_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StInit    = 3'd1,
      StShuffle = 3'd2,
      StDecrypt = 3'd3,
      StNextKey = 3'd4,
      StFound   = 3'd5,
      StFail    = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      ClientInit    = 2'd0,
      ClientShuffle = 2'd1,
      ClientDecrypt = 2'd2,
      ClientNone    = 2'd3
   } client_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              wren;
   } s_req_t;

   // Which client owns the S-memory in a given state.
   function automatic client_e state_to_client(input state_e st);
      client_e c;
      case (st)
         StInit:    c = ClientInit;
         StShuffle: c = ClientShuffle;
         StDecrypt: c = ClientDecrypt;
         default:   c = ClientNone;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/rc4_key_search_sequencer_if.sv
// Signal bundle between the key-search sequencer and its environment.
//   go/abort                      : search control (levels)
//   {init,shuffle,decrypt}_start  : client start levels from the sequencer
//   {init,shuffle,decrypt}_finished, decrypt_valid : client completion
//   {init,shuffle,decrypt}_addr/_data/_wren : per-client S-memory requests
//   s_addr/s_data/s_wren          : granted S-memory port
//   secret_key, phase, busy, found, failed, timeout : status
// Modports: slave = the sequencer, master = the environment driving it.
interface rc4_key_search_sequencer_if #(
   parameter int unsigned KEY_W = 24
);
   import rc4_seq_pkg::*;

   logic              go;
   logic              abort;

   logic              init_start;
   logic              init_finished;
   logic              shuffle_start;
   logic              shuffle_finished;
   logic              decrypt_start;
   logic              decrypt_finished;
   logic              decrypt_valid;

   logic [ADDR_W-1:0] init_addr;
   logic [DATA_W-1:0] init_data;
   logic              init_wren;
   logic [ADDR_W-1:0] shuffle_addr;
   logic [DATA_W-1:0] shuffle_data;
   logic              shuffle_wren;
   logic [ADDR_W-1:0] decrypt_addr;
   logic [DATA_W-1:0] decrypt_data;
   logic              decrypt_wren;

   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_data;
   logic              s_wren;

   logic [KEY_W-1:0]  secret_key;
   logic [2:0]        phase;
   logic              busy;
   logic              found;
   logic              failed;
   logic              timeout;

   modport slave (
      input  go, abort,
      input  init_finished, shuffle_finished, decrypt_finished, decrypt_valid,
      input  init_addr, init_data, init_wren,
      input  shuffle_addr, shuffle_data, shuffle_wren,
      input  decrypt_addr, decrypt_data, decrypt_wren,
      output init_start, shuffle_start, decrypt_start,
      output s_addr, s_data, s_wren,
      output secret_key, phase, busy, found, failed, timeout
   );

   modport master (
      output go, abort,
      output init_finished, shuffle_finished, decrypt_finished, decrypt_valid,
      output init_addr, init_data, init_wren,
      output shuffle_addr, shuffle_data, shuffle_wren,
      output decrypt_addr, decrypt_data, decrypt_wren,
      input  init_start, shuffle_start, decrypt_start,
      input  s_addr, s_data, s_wren,
      input  secret_key, phase, busy, found, failed, timeout
   );

endinterface

// File: rtl/s_mem_port_mux.sv
// Routes the request of the granted S-memory client to the single S-memory port.
//   grant       : client index; ClientNone drives an all-zero (no write) request
//   req_init/req_shuffle/req_decrypt : per-client requests
//   port        : granted request, purely combinational
module s_mem_port_mux
   import rc4_seq_pkg::*;
(
   input  client_e grant,
   input  s_req_t  req_init,
   input  s_req_t  req_shuffle,
   input  s_req_t  req_decrypt,
   output s_req_t  port
);

   always_comb begin
      port = '0;
      case (grant)
         ClientInit:    port = req_init;
         ClientShuffle: port = req_shuffle;
         ClientDecrypt: port = req_decrypt;
         default:       port = '0;
      endcase
   end

endmodule

// File: rtl/rc4_key_search_sequencer.sv
// Top-level scheduler of the RC4 key-search datapath. For each candidate key it runs the
// init, shuffle and decrypt S-memory clients in order, grants the single-port S-memory to
// the active client only, and steps the key until decrypt reports a valid plaintext or the
// key space (0..KEY_MAX) is exhausted.
//   clk, reset : single clock; synchronous active-high reset
//   bus        : rc4_key_search_sequencer_if.slave (control, client handshakes, S-mem, status)
// Parameters: KEY_W (key width), KEY_MAX (last key tried), WDOG_CYCLES (per-phase limit).
// Optional build macro RC4_SEQ_WATCHDOG_EN: when defined, a phase that runs WDOG_CYCLES
// cycles without finishing goes to FAIL with timeout=1; otherwise timeout is tied to 0 and
// a phase waits indefinitely.
module rc4_key_search_sequencer
   import rc4_seq_pkg::*;
#(
   parameter int unsigned      KEY_W       = 24,
   parameter logic [KEY_W-1:0] KEY_MAX     = {KEY_W{1'b1}},
   parameter int unsigned      WDOG_CYCLES = 4096
) (
   input logic                       clk,
   input logic                       reset,
   rc4_key_search_sequencer_if.slave bus
);

   state_e           state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   // High during the first cycle after entering any state; a finished level still held
   // from the previous pass must not end the new phase.
   logic             arm_q;
   logic             active_finished;
   logic             phase_done;
   logic             wdog_expired;

   s_req_t           req_init, req_shuffle, req_decrypt, s_port;
   client_e          grant;

   // ---------------------------------------------------------------------------------------
   // Completion of the client that owns the current phase; other clients are ignored.
   // ---------------------------------------------------------------------------------------
   always_comb begin
      active_finished = 1'b0;
      case (state_q)
         StInit:    active_finished = bus.init_finished;
         StShuffle: active_finished = bus.shuffle_finished;
         StDecrypt: active_finished = bus.decrypt_finished;
         default:   active_finished = 1'b0;
      endcase
   end

   assign phase_done = active_finished & ~arm_q;

   // ---------------------------------------------------------------------------------------
   // Next-state logic. Abort overrides every transition; reset overrides abort in the flop.
   // ---------------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      if (bus.abort) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.go) begin
                  state_d = StInit;
                  key_d   = '0;
               end
            end
            StInit: begin
               if (phase_done)        state_d = StShuffle;
               else if (wdog_expired) state_d = StFail;
            end
            StShuffle: begin
               if (phase_done)        state_d = StDecrypt;
               else if (wdog_expired) state_d = StFail;
            end
            StDecrypt: begin
               if (phase_done)        state_d = bus.decrypt_valid ? StFound : StNextKey;
               else if (wdog_expired) state_d = StFail;
            end
            StNextKey: begin
               // Compare before incrementing so the key never wraps past KEY_MAX.
               if (key_q == KEY_MAX) begin
                  state_d = StFail;
               end else begin
                  key_d   = key_q + 1'b1;
                  state_d = StInit;
               end
            end
            StFound, StFail: begin
               if (!bus.go) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         key_q   <= '0;
         arm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         arm_q   <= (state_d != state_q);
      end
   end

   // ---------------------------------------------------------------------------------------
   // Per-phase watchdog
   // ---------------------------------------------------------------------------------------
`ifdef RC4_SEQ_WATCHDOG_EN
   localparam int unsigned   WdogW    = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);

   logic             in_phase;
   logic [WdogW-1:0] wdog_q, wdog_d;
   logic             timeout_q, timeout_d;

   assign in_phase = state_q inside {StInit, StShuffle, StDecrypt};
   // Counter reads k in the k-th cycle after entry, so the phase is left exactly
   // WDOG_CYCLES edges after it was entered.
   assign wdog_expired = in_phase & (wdog_q == WdogLast);

   always_comb begin
      wdog_d    = wdog_q;
      timeout_d = timeout_q;
      if (state_d != state_q) begin
         wdog_d = '0;
      end else if (in_phase) begin
         wdog_d = wdog_q + 1'b1;
      end
      if (state_d == StIdle) begin
         timeout_d = 1'b0;
      end else if (wdog_expired && (state_d == StFail)) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         wdog_q    <= wdog_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.timeout = timeout_q;
`else
   logic unused_wdog;

   assign wdog_expired = 1'b0;
   assign bus.timeout  = 1'b0;
   assign unused_wdog  = ^WDOG_CYCLES;
`endif

   // ---------------------------------------------------------------------------------------
   // S-memory grant: combinational on registered state, zero outside the phase states.
   // ---------------------------------------------------------------------------------------
   assign grant       = state_to_client(state_q);
   assign req_init    = '{addr: bus.init_addr,    data: bus.init_data,    wren: bus.init_wren};
   assign req_shuffle = '{addr: bus.shuffle_addr, data: bus.shuffle_data, wren: bus.shuffle_wren};
   assign req_decrypt = '{addr: bus.decrypt_addr, data: bus.decrypt_data, wren: bus.decrypt_wren};

   s_mem_port_mux u_s_mem_port_mux (
      .grant       (grant),
      .req_init    (req_init),
      .req_shuffle (req_shuffle),
      .req_decrypt (req_decrypt),
      .port        (s_port)
   );

   assign bus.s_addr = s_port.addr;
   assign bus.s_data = s_port.data;
   assign bus.s_wren = s_port.wren;

   // ---------------------------------------------------------------------------------------
   // Decoded outputs
   // ---------------------------------------------------------------------------------------
   assign bus.init_start    = (state_q == StInit);
   assign bus.shuffle_start = (state_q == StShuffle);
   assign bus.decrypt_start = (state_q == StDecrypt);
   assign bus.busy          = state_q inside {StInit, StShuffle, StDecrypt, StNextKey};
   assign bus.found         = (state_q == StFound);
   assign bus.failed        = (state_q == StFail);
   assign bus.phase         = state_q;
   assign bus.secret_key    = key_q;

endmodule

// File: tb/tb_rc4_key_search_sequencer.sv
module tb_rc4_key_search_sequencer;
   import rc4_seq_pkg::*;

   localparam int unsigned      KW        = 24;
   localparam logic [KW-1:0]    KMAX      = 3;
   localparam int               WDOG_MAIN = 4096;
   localparam int               WDOG_TEST = 100;
`ifdef RC4_SEQ_WATCHDOG_EN
   localparam bit               WDOG_ON   = 1'b1;
`else
   localparam bit               WDOG_ON   = 1'b0;
`endif

   localparam int P_IDLE = 0, P_INIT = 1, P_SHUF = 2, P_DEC = 3, P_NEXT = 4, P_FOUND = 5,
                  P_FAIL = 6;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   rc4_key_search_sequencer_if #(.KEY_W(KW)) bus ();
   rc4_key_search_sequencer_if #(.KEY_W(KW)) wbus ();

   rc4_key_search_sequencer #(.KEY_W(KW), .KEY_MAX(KMAX), .WDOG_CYCLES(WDOG_MAIN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   rc4_key_search_sequencer #(.KEY_W(KW), .KEY_MAX(KMAX), .WDOG_CYCLES(WDOG_TEST)) u_wdog (
      .clk   (clk),
      .reset (reset),
      .bus   (wbus)
   );

   // ---------------- stub clients for the main instance ----------------
   int lat_i = 1, lat_s = 1, lat_d = 1;
   int cnt_i = 0, cnt_s = 0, cnt_d = 0;
   bit init_force = 1'b0;
   int valid_key = -1;

   always @(posedge clk) begin
      cnt_i <= (bus.init_start    === 1'b1) ? cnt_i + 1 : 0;
      cnt_s <= (bus.shuffle_start === 1'b1) ? cnt_s + 1 : 0;
      cnt_d <= (bus.decrypt_start === 1'b1) ? cnt_d + 1 : 0;
   end

   assign bus.init_finished    = init_force | ((bus.init_start === 1'b1) && cnt_i >= lat_i);
   assign bus.shuffle_finished = (bus.shuffle_start === 1'b1) && cnt_s >= lat_s;
   assign bus.decrypt_finished = (bus.decrypt_start === 1'b1) && cnt_d >= lat_d;
   assign bus.decrypt_valid    = (valid_key >= 0) && (bus.secret_key == KW'(valid_key));

   // Watchdog instance: init finishes at once, shuffle never does.
   assign wbus.init_finished    = wbus.init_start;
   assign wbus.shuffle_finished = 1'b0;
   assign wbus.decrypt_finished = 1'b0;
   assign wbus.decrypt_valid    = 1'b0;
   assign wbus.init_addr = '0;    assign wbus.init_data = '0;    assign wbus.init_wren = 1'b0;
   assign wbus.shuffle_addr = '0; assign wbus.shuffle_data = '0; assign wbus.shuffle_wren = 1'b0;
   assign wbus.decrypt_addr = '0; assign wbus.decrypt_data = '0; assign wbus.decrypt_wren = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: phase name, cycles spent in it, key ----------------
   int              m_ph  = P_IDLE;
   int              m_age = 0;
   logic [KW-1:0]   m_key = '0;
   bit              m_to  = 1'b0;

   always @(posedge clk) begin : model
      int            ph;
      logic [KW-1:0] k;
      bit            to;
      bit            fin;
      ph = m_ph; k = m_key; to = m_to;
      if (reset) begin
         ph = P_IDLE; k = '0; to = 1'b0;
      end else if (bus.abort) begin
         ph = P_IDLE;
      end else begin
         case (m_ph)
            P_IDLE: if (bus.go) begin ph = P_INIT; k = '0; end
            P_INIT, P_SHUF, P_DEC: begin
               fin = (m_ph == P_INIT) ? bus.init_finished :
                     (m_ph == P_SHUF) ? bus.shuffle_finished : bus.decrypt_finished;
               if (m_age > 0 && fin)
                  ph = (m_ph == P_DEC) ? (bus.decrypt_valid ? P_FOUND : P_NEXT) : m_ph + 1;
               else if (WDOG_ON && m_age == WDOG_MAIN - 1) begin
                  ph = P_FAIL; to = 1'b1;
               end
            end
            P_NEXT: if (k == KMAX) ph = P_FAIL; else begin k = k + 1'b1; ph = P_INIT; end
            P_FOUND, P_FAIL: if (!bus.go) ph = P_IDLE;
            default: ph = P_IDLE;
         endcase
      end
      if (ph == P_IDLE) to = 1'b0;
      m_age <= (ph != m_ph) ? 0 : m_age + 1;
      m_ph  <= ph;
      m_key <= k;
      m_to  <= to;
   end

   // ---------------- per-cycle compare, then fresh random client requests ----------------
   bit cmp_en = 1'b0;

   always @(negedge clk) begin : compare
      logic [7:0] ea, ed;
      logic       ew;
      if (cmp_en) begin
         case (m_ph)
            P_INIT:  begin ea = bus.init_addr;    ed = bus.init_data;    ew = bus.init_wren;    end
            P_SHUF:  begin ea = bus.shuffle_addr; ed = bus.shuffle_data; ew = bus.shuffle_wren; end
            P_DEC:   begin ea = bus.decrypt_addr; ed = bus.decrypt_data; ew = bus.decrypt_wren; end
            default: begin ea = '0; ed = '0; ew = 1'b0; end
         endcase
         check("phase", 64'(bus.phase), 64'(m_ph));
         check("starts", {bus.init_start, bus.shuffle_start, bus.decrypt_start},
               {m_ph == P_INIT, m_ph == P_SHUF, m_ph == P_DEC});
         check("status", {bus.busy, bus.found, bus.failed, bus.timeout},
               {(m_ph >= P_INIT && m_ph <= P_NEXT), m_ph == P_FOUND, m_ph == P_FAIL, m_to});
         check("secret_key", bus.secret_key, m_key);
         check("s_port", {bus.s_addr, bus.s_data, bus.s_wren}, {ea, ed, ew});
      end
      bus.init_addr    = 8'($urandom); bus.init_data    = 8'($urandom);
      bus.init_wren    = 1'($urandom);
      bus.shuffle_addr = 8'($urandom); bus.shuffle_data = 8'($urandom);
      bus.shuffle_wren = 1'($urandom);
      bus.decrypt_addr = 8'($urandom); bus.decrypt_data = 8'($urandom);
      bus.decrypt_wren = 1'($urandom);
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Run until found/failed or budget expires; reports INIT entries and busy cycles.
   task automatic run_search(input int budget, output int entries, output int busy_n,
                             output bit done);
      bit prev = 1'b0;
      entries = 0; busy_n = 0; done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.init_start && !prev) entries++;
         prev = bus.init_start;
         if (bus.busy) busy_n++;
         if (bus.found || bus.failed) begin done = 1'b1; break; end
      end
   endtask

   initial begin : watchdog_timer
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      int  ent, bsy, cnt;
      bit  done;
      bus.go = 1'b0; bus.abort = 1'b0;
      wbus.go = 1'b0; wbus.abort = 1'b0;
      bus.init_addr = '0; bus.init_data = '0; bus.init_wren = 1'b0;
      bus.shuffle_addr = '0; bus.shuffle_data = '0; bus.shuffle_wren = 1'b0;
      bus.decrypt_addr = '0; bus.decrypt_data = '0; bus.decrypt_wren = 1'b0;
      @(posedge clk);
      cmp_en = 1'b1;
      cycles(2);
      reset = 1'b0;
      check("reset_phase", 64'(bus.phase), 64'(P_IDLE));
      check("reset_key", bus.secret_key, 0);
      check("reset_wren", bus.s_wren, 0);
      cycles(2);

      // 1: long client latencies, valid on key 0
      lat_i = 256; lat_s = 256; lat_d = 40; valid_key = 0;
      bus.go = 1'b1;
      run_search(2000, ent, bsy, done);
      check("t1_done", done, 1);
      check("t1_found", bus.found, 1);
      check("t1_key", bus.secret_key, 0);
      check("t1_busy_cycles", bsy, 555);
      bus.go = 1'b0;
      cycles(2);
      check("t1_back_idle", 64'(bus.phase), 64'(P_IDLE));

      // 2: keys 0,1 invalid, key 2 valid
      lat_i = 3; lat_s = 4; lat_d = 2; valid_key = 2;
      bus.go = 1'b1;
      run_search(500, ent, bsy, done);
      check("t2_found", bus.found, 1);
      check("t2_init_entries", ent, 3);
      check("t2_key", bus.secret_key, 2);
      bus.go = 1'b0;
      cycles(2);

      // 3: never valid -> fail after key 3, no wrap
      valid_key = -1;
      bus.go = 1'b1;
      run_search(500, ent, bsy, done);
      check("t3_failed", bus.failed, 1);
      check("t3_init_entries", ent, 4);
      cycles(5);
      check("t3_key_held", bus.secret_key, 3);
      check("t3_still_failed", bus.failed, 1);
      bus.go = 1'b0;
      cycles(2);

      // 4: init_finished already high when INIT is entered
      init_force = 1'b1; lat_s = 2; lat_d = 2; valid_key = 0;
      bus.go = 1'b1;
      @(negedge clk);
      check("t4_arm_starts", {bus.init_start, bus.shuffle_start}, 2'b10);
      cnt = 1;
      for (int i = 0; i < 20 && !bus.shuffle_start; i++) begin
         @(negedge clk);
         if (bus.init_start) cnt++;
      end
      check("t4_init_cycles", cnt, 2);
      check("t4_shuffle_start", bus.shuffle_start, 1);
      init_force = 1'b0;
      run_search(200, ent, bsy, done);
      check("t4_found", bus.found, 1);
      bus.go = 1'b0;
      cycles(2);

      // 5: reset mid-SHUFFLE, abort mid-DECRYPT
      lat_i = 3; lat_s = 6; lat_d = 4; valid_key = -1;
      bus.go = 1'b1;
      for (int i = 0; i < 300 && !(bus.secret_key == 1 && bus.shuffle_start); i++)
         @(negedge clk);
      check("t5_reach_shuffle", {bus.secret_key == 1, bus.shuffle_start}, 2'b11);
      cycles(2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5_rst_phase", 64'(bus.phase), 64'(P_IDLE));
      check("t5_rst_starts", {bus.init_start, bus.shuffle_start, bus.decrypt_start}, 0);
      check("t5_rst_wren", bus.s_wren, 0);
      check("t5_rst_key", bus.secret_key, 0);
      for (int i = 0; i < 300 && !(bus.secret_key == 2 && bus.decrypt_start); i++)
         @(negedge clk);
      check("t5_reach_decrypt", {bus.secret_key == 2, bus.decrypt_start}, 2'b11);
      cycles(1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0; bus.go = 1'b0;
      check("t5_abort_phase", 64'(bus.phase), 64'(P_IDLE));
      check("t5_abort_starts", {bus.init_start, bus.shuffle_start, bus.decrypt_start}, 0);
      check("t5_abort_wren", bus.s_wren, 0);
      check("t5_abort_key", bus.secret_key, 2);
      cycles(2);

      // 6: watchdog instance, shuffle never finishes
      wbus.go = 1'b1;
      cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (wbus.shuffle_start) cnt++;
         if (wbus.failed) break;
      end
`ifdef RC4_SEQ_WATCHDOG_EN
      check("t6_shuffle_cycles", cnt, WDOG_TEST);
      check("t6_fail_timeout", {wbus.failed, wbus.timeout}, 2'b11);
      wbus.go = 1'b0;
      @(negedge clk);
      check("t6_timeout_cleared", {wbus.phase, wbus.timeout}, 4'b0000);
`else
      check("t6_shuffle_cycles", cnt, 998);
      check("t6_still_shuffle", 64'(wbus.phase), 64'(P_SHUF));
      check("t6_no_timeout", wbus.timeout, 0);
      wbus.abort = 1'b1;
      @(negedge clk);
      wbus.abort = 1'b0; wbus.go = 1'b0;
      check("t6_abort_idle", 64'(wbus.phase), 64'(P_IDLE));
`endif

      // Random searches with random latencies, target and at most one abort each
      for (int t = 0; t < 8; t++) begin
         bit aborted = 1'b0;
         lat_i = $urandom_range(1, 12); lat_s = $urandom_range(1, 12);
         lat_d = $urandom_range(1, 12); valid_key = $urandom_range(0, 4);
         bus.go = 1'b1;
         done = 1'b0;
         for (int i = 0; i < 1500 && !done; i++) begin
            @(negedge clk);
            bus.abort = 1'b0;
            if (bus.found || bus.failed) done = 1'b1;
            else if (!aborted && $urandom_range(0, 99) == 0) begin
               bus.abort = 1'b1; aborted = 1'b1;
            end
         end
         bus.abort = 1'b0;
         check("rand_done", done, 1);
         bus.go = 1'b0;
         cycles(3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
